// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single-port data
//             memory (combinational read, posedge write). Each access takes
//             one ACCESS cycle followed by one DONE cycle that pulses the
//             owner's ack together with its registered read data.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    // port 0: processor load/store path
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  ack0,
    // port 1: debug/loader path
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ack1,
    // memory side
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_owner;
    logic                  w_next_owner;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_ack0;
    logic                  r_ack1;

    // Owner-selected request fields; the arbiter never alters address/data.
    logic                  w_own_we;
    logic [ADDR_WIDTH-1:0] w_own_addr;
    logic [DATA_WIDTH-1:0] w_own_wdata;
    logic                  w_own_req;
    logic                  w_other_req;

    assign w_own_we    = r_owner ? we1    : we0;
    assign w_own_addr  = r_owner ? addr1  : addr0;
    assign w_own_wdata = r_owner ? wdata1 : wdata0;
    assign w_own_req   = r_owner ? req1   : req0;
    assign w_other_req = r_owner ? req0   : req1;

    // State register: current state and the port that owns the memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
        end
    end

    // Next-state logic: round-robin grant in IDLE, back-to-back hand-off in DONE.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_next_state = S_ACCESS;
                    // On contention the port that did not go last wins.
                    w_next_owner = (req0 && req1) ? ~r_last : req1;
                end
            end
            S_ACCESS: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_other_req) begin
                    w_next_state = S_ACCESS;
                    w_next_owner = ~r_owner;
                end else if (w_own_req) begin
                    w_next_state = S_ACCESS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_owner = 1'b0;
            end
        endcase
    end

    // Access bookkeeping: fairness history, read-data capture and ack pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last   <= 1'b1;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
        end else begin
            // ACCESS always moves to DONE, so the ack lands exactly in DONE.
            r_ack0 <= (r_state == S_ACCESS) && !r_owner;
            r_ack1 <= (r_state == S_ACCESS) &&  r_owner;
            if (r_state == S_ACCESS) begin
                r_last <= r_owner;
                if (!w_own_we) begin
                    if (r_owner) begin
                        r_rdata1 <= mem_rdata;
                    end else begin
                        r_rdata0 <= mem_rdata;
                    end
                end
            end
        end
    end

    // Output logic: memory pins are only driven during ACCESS.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (r_state == S_ACCESS) begin
            mem_addr  = w_own_addr;
            mem_wdata = w_own_wdata;
            // Gating with reset keeps a write from committing on a reset edge.
            mem_write = w_own_we & reset;
            mem_read  = ~w_own_we;
        end
    end

    assign busy   = (r_state == S_ACCESS) || (r_state == S_DONE);
    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_data_memory_arbiter
//  Purpose  : Self-checking bench for data_memory_arbiter with a behavioural
//             256-word memory, a transaction table and corner-case sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          ack0, ack1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read, busy;

    always #5 clk = ~clk;

    data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .rdata1(rdata1), .ack1(ack1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Behavioural data memory: combinational read, posedge write.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = 32'h0000_0011;
        mem[2] = 32'h0000_0022;
    end

    typedef struct {
        int          port;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          port;
        bit          is_read;
        logic [31:0] data;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int port, input bit is_read, input logic [31:0] data);
        sb_t it;
        it.port = port; it.is_read = is_read; it.data = data;
        sb.push_back(it);
    endtask

    // Advance one cycle, sample after the edge and score any ack.
    task automatic tick();
        sb_t it;
        @(posedge clk);
        #1;
        chk("ack_exclusive", {31'd0, ack0 & ack1}, 0);
        if (ack0 || ack1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 0);
            end else begin
                it = sb.pop_front();
                chk("ack_port", ack1 ? 1 : 0, it.port);
                if (it.is_read) chk("ack_rdata", it.port != 0 ? rdata1 : rdata0, it.data);
            end
        end
    endtask

    task automatic drive(input int port, input bit r, input bit we,
                         input logic [7:0] a, input logic [31:0] d);
        if (port == 0) begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 8'h00, 32'h0);
        drive(1, 0, 0, 8'h00, 32'h0);
        tick();
        tick();
    endtask

    // Single isolated access: checks memory pins in ACCESS and 2-cycle latency.
    task automatic access(input int port, input bit we, input logic [7:0] a,
                          input logic [31:0] d, input logic [31:0] exp);
        int n;
        bit got;
        push_exp(port, !we, exp);
        drive(port, 1, we, a, d);
        n = 0;
        got = 0;
        while (!got && n < 6) begin
            tick();
            n++;
            if (n == 1) begin
                chk("acc_mem_write", {31'd0, mem_write}, {31'd0, we});
                chk("acc_mem_read", {31'd0, mem_read}, {31'd0, !we});
                chk("acc_mem_addr", {24'd0, mem_addr}, {24'd0, a});
                if (we) chk("acc_mem_wdata", mem_wdata, d);
                chk("acc_busy", {31'd0, busy}, 1);
            end
            got = (port == 0) ? ack0 : ack1;
        end
        chk("ack_latency", got ? n : 0, 2);
        if (got) begin
            chk("done_mem_write", {31'd0, mem_write}, 0);
            chk("done_mem_addr", {24'd0, mem_addr}, 0);
        end
        drive(port, 0, we, a, d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, prev, n, cur;

        vecs[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1, 1'b1, 8'h30, 32'h12345678, 32'h0};
        vecs[4] = '{0, 1'b0, 8'h30, 32'h0,        32'h12345678};
        vecs[5] = '{1, 1'b0, 8'h01, 32'h0,        32'h00000011};
        vecs[6] = '{0, 1'b1, 8'h00, 32'hA5A5A5A5, 32'h0};
        vecs[7] = '{1, 1'b0, 8'h00, 32'h0,        32'hA5A5A5A5};

        // Reset state
        do_reset();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_acks", {30'd0, ack1, ack0}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_ctl", {30'd0, mem_write, mem_read}, 0);
        reset = 1'b1;
        tick();

        // Transaction table, including the write/read-back of DEADBEEF
        for (int i = 0; i < 8; i++) begin
            access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
            tick();
        end

        // Simultaneous reads right after reset: port 0 first, then port 1 back-to-back
        do_reset();
        reset = 1'b1;
        push_exp(0, 1, 32'h11);
        push_exp(1, 1, 32'h22);
        drive(0, 1, 0, 8'h01, 32'h0);
        drive(1, 1, 0, 8'h02, 32'h0);
        tick();
        chk("both_first_addr", {24'd0, mem_addr}, 8'h01);
        tick();
        chk("both_ack0", {31'd0, ack0}, 1);
        drive(0, 0, 0, 8'h01, 32'h0);
        tick();
        chk("both_direct_access", {24'd0, mem_addr}, 8'h02);
        chk("both_busy", {31'd0, busy}, 1);
        tick();
        chk("both_ack1", {31'd0, ack1}, 1);
        drive(1, 0, 0, 8'h02, 32'h0);
        tick();
        chk("both_idle_after", {31'd0, busy}, 0);

        // Continuous demand from both ports: strict alternation
        for (int k = 0; k < 8; k++)
            push_exp(k % 2, 1, (k % 2) != 0 ? 32'h12345678 : 32'hDEADBEEF);
        drive(0, 1, 0, 8'h10, 32'h0);
        drive(1, 1, 0, 8'h30, 32'h0);
        acks = 0; prev = -1; n = 0;
        while (acks < 8 && n < 40) begin
            tick();
            n++;
            chk("fair_busy", {31'd0, busy}, 1);
            if (ack0 || ack1) begin
                cur = ack1 ? 1 : 0;
                if (prev >= 0) chk("fair_alternate", cur, 1 - prev);
                prev = cur;
                acks++;
            end
        end
        drive(0, 0, 0, 8'h10, 32'h0);
        drive(1, 0, 0, 8'h30, 32'h0);
        chk("fair_count", acks, 8);
        chk("fair_cycles", n, 16);
        tick();
        tick();
        chk("fair_idle_after", {31'd0, busy}, 0);

        // Port 1 write with req dropped during ACCESS
        push_exp(1, 0, 32'h0);
        drive(1, 1, 1, 8'hFF, 32'h5A5A5A5A);
        tick();
        chk("drop_mem_write", {31'd0, mem_write}, 1);
        drive(1, 0, 1, 8'hFF, 32'h5A5A5A5A);
        tick();
        chk("drop_ack1", {31'd0, ack1}, 1);
        tick();
        chk("drop_ack1_once", {31'd0, ack1}, 0);
        access(0, 0, 8'hFF, 32'h0, 32'h5A5A5A5A);
        tick();

        // Reset during a write ACCESS: write suppressed, no ack
        drive(0, 1, 1, 8'h20, 32'hCAFEF00D);
        tick();
        chk("rstacc_pre_write", {31'd0, mem_write}, 1);
        reset = 1'b0;
        drive(0, 0, 1, 8'h20, 32'hCAFEF00D);
        #1;
        chk("rstacc_write_gated", {31'd0, mem_write}, 0);
        tick();
        chk("rstacc_busy", {31'd0, busy}, 0);
        chk("rstacc_ack0", {31'd0, ack0}, 0);
        reset = 1'b1;
        tick();
        tick();
        chk("rstacc_no_late_ack", {31'd0, ack0}, 0);
        access(1, 0, 8'h20, 32'h0, 32'h0);
        tick();
        access(0, 0, 8'hFF, 32'h0, 32'h5A5A5A5A);
        tick();
        access(1, 0, 8'h10, 32'h0, 32'hDEADBEEF);

        // Idle bus: nothing driven, read data held
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_mem_ctl", {30'd0, mem_write, mem_read}, 0);
            chk("idle_mem_addr", {24'd0, mem_addr}, 0);
            chk("idle_mem_wdata", mem_wdata, 0);
            chk("idle_busy_ack", {29'd0, busy, ack1, ack0}, 0);
            chk("idle_rdata0", rdata0, 32'h5A5A5A5A);
            chk("idle_rdata1", rdata1, 32'hDEADBEEF);
        end

        // Reset during DONE clears the ack
        push_exp(0, 1, 32'h12345678);
        drive(0, 1, 0, 8'h30, 32'h0);
        tick();
        tick();
        chk("rstdone_ack0_seen", {31'd0, ack0}, 1);
        reset = 1'b0;
        drive(0, 0, 0, 8'h30, 32'h0);
        tick();
        chk("rstdone_ack0_clear", {31'd0, ack0}, 0);
        chk("rstdone_busy", {31'd0, busy}, 0);
        reset = 1'b1;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
